gapu_job_sched: RTL

Round-robin job scheduler that shares one GAPU geometric-product core between N_REQ requesters. Each requester submits a job as three operand/result base addresses. The scheduler grants one job at a time and launches the core with a single-cycle start pulse. It waits for the core's done pulse, then returns a per-requester completion with the measured run time. It sits between the host-side job ports and the core's start/busy/done control interface.

---
 rtl/gapu_job_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gapu_job_sched.sv
// Round-robin job scheduler that time-shares one GAPU geometric-product core between N_REQ requesters.
// Optional run-time watchdog enabled by defining GAPU_SCHED_TIMEOUT_EN.
module gapu_job_sched #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 16,
  parameter int CYC_W       = 16,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_a_base,
  input  logic [N_REQ*ADDR_W-1:0] req_b_base,
  input  logic [N_REQ*ADDR_W-1:0] req_c_base,
  output logic                    core_start,
  input  logic                    core_busy,
  input  logic                    core_done,
  output logic [ADDR_W-1:0]       core_a_base,
  output logic [ADDR_W-1:0]       core_b_base,
  output logic [ADDR_W-1:0]       core_c_base,
  output logic [N_REQ-1:0]        resp_valid,
  output logic                    resp_err,
  output logic [CYC_W-1:0]        resp_cycles,
  output logic                    sched_busy
);

  localparam int PTR_W = $clog2(N_REQ);

`ifdef GAPU_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam logic [CYC_W-1:0] TIMEOUT_LIM = CYC_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RESP
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] cur_id;
  logic [PTR_W-1:0] win_id;
  logic [PTR_W-1:0] rr_next;
  logic             win_found;
  logic             accept;
  logic [CYC_W-1:0] run_cnt;
  logic [CYC_W-1:0] cnt_next;
  logic             timeout_hit;
  int               scan_idx;

  // Scan upward from rr_ptr, wrapping, and take the first pending requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = int'(rr_ptr) + i;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = PTR_W'(scan_idx);
      end
    end
  end

  assign accept  = (state == S_IDLE) && !core_busy && win_found;
  assign rr_next = (win_id == PTR_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept && !rst) req_ready[win_id] = 1'b1;
  end

  // Count includes the current RUN cycle, so a done seen here reports it.
  assign cnt_next    = (&run_cnt) ? run_cnt : run_cnt + 1'b1;
  assign timeout_hit = TIMEOUT_ON && (cnt_next == TIMEOUT_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      run_cnt     <= '0;
      core_start  <= 1'b0;
      core_a_base <= '0;
      core_b_base <= '0;
      core_c_base <= '0;
      resp_valid  <= '0;
      resp_err    <= 1'b0;
      resp_cycles <= '0;
      sched_busy  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      resp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            core_a_base <= req_a_base[win_id*ADDR_W +: ADDR_W];
            core_b_base <= req_b_base[win_id*ADDR_W +: ADDR_W];
            core_c_base <= req_c_base[win_id*ADDR_W +: ADDR_W];
            cur_id      <= win_id;
            rr_ptr      <= rr_next;
            core_start  <= 1'b1;
            sched_busy  <= 1'b1;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          run_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          run_cnt <= cnt_next;
          // A done in the same cycle as the watchdog limit still counts as success.
          if (core_done) begin
            resp_cycles <= cnt_next;
            resp_err    <= 1'b0;
            resp_valid  <= N_REQ'(1) << cur_id;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            resp_cycles <= cnt_next;
            resp_err    <= 1'b1;
            resp_valid  <= N_REQ'(1) << cur_id;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          sched_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
